fft_radix2_bfly_pipe: RTL and testbench

Parametrised, fully pipelined radix-2 butterfly for the streaming FFT datapath, succeeding the fixed DIF butterfly. Supports DIF and DIT per beat, optional 1/2 scaling per beat, and convergent-free round-half-up twiddle rounding. Outputs are saturated to WIDTH with sticky per-component overflow flags. Uses a valid/ready handshake with global-stall backpressure so it can sit between stage FIFOs.

---
 rtl/fft_pkg.sv | 55 +++++
 rtl/cmul_pipe.sv | 75 +++++++
 rtl/fft_radix2_bfly_pipe.sv | 164 ++++++++++++++++
 tb/tb_fft_radix2_bfly_pipe.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT helpers: twiddle width, overflow flag layout, round/saturate.
// Arithmetic helpers work on a wide signed accumulator so every stage of the
// FFT can reuse them regardless of its own data width.
package fft_pkg;

  localparam int ACC_W = 64;
  typedef logic signed [ACC_W-1:0] acc_t;

  // ovf_o bit positions
  localparam int OVF_X1_RE = 0;
  localparam int OVF_X1_IM = 1;
  localparam int OVF_X2_RE = 2;
  localparam int OVF_X2_IM = 3;

  // per-beat mode bits that travel down the pipe with the data
  typedef struct packed {
    logic dif;
    logic scale;
  } bfly_mode_t;

  // Q1.WN twiddle needs a sign bit and an integer bit so that 1.0 fits
  function automatic int tw_width(input int wn_width);
    return wn_width + 2;
  endfunction

  // round half up: (v + 2^(frac-1)) >>> frac, frac >= 1
  function automatic acc_t round_half_up(input acc_t v, input int frac);
    acc_t bias;
    bias = acc_t'(1) <<< (frac - 1);
    return (v + bias) >>> frac;
  endfunction

  function automatic acc_t sat_max(input int w);
    return (acc_t'(1) <<< (w - 1)) - acc_t'(1);
  endfunction

  function automatic acc_t sat_min(input int w);
    return -(acc_t'(1) <<< (w - 1));
  endfunction

  // 1 when v does not fit a signed w-bit word
  function automatic logic sat_hit(input acc_t v, input int w);
    return (v > sat_max(w)) || (v < sat_min(w));
  endfunction

  // clamp v into the signed w-bit range
  function automatic acc_t saturate(input acc_t v, input int w);
    acc_t r;
    if (v > sat_max(w))      r = sat_max(w);
    else if (v < sat_min(w)) r = sat_min(w);
    else                     r = v;
    return r;
  endfunction

endpackage

// File: rtl/cmul_pipe.sv
// Pipelined full-precision complex multiply (4 real multipliers).
// First register holds the four partial products, the remaining STAGES-1
// registers carry the summed result. Everything advances only under ce_i.
module cmul_pipe
  import fft_pkg::*;
#(
  parameter int AW     = 17,
  parameter int BW     = 16,
  parameter int STAGES = 3,
  localparam int PW    = AW + BW + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 ce_i,
  input  logic signed [AW-1:0] ar_i,
  input  logic signed [AW-1:0] ai_i,
  input  logic signed [BW-1:0] br_i,
  input  logic signed [BW-1:0] bi_i,
  output logic signed [PW-1:0] pr_o,
  output logic signed [PW-1:0] pi_o
);

  localparam int MW = AW + BW;

  logic signed [MW-1:0] m_rr, m_ii, m_ri, m_ir;
  logic signed [PW-1:0] s_re, s_im;

  // stage 1: partial products
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      m_rr <= '0;
      m_ii <= '0;
      m_ri <= '0;
      m_ir <= '0;
    end else if (ce_i) begin
      m_rr <= MW'(ar_i) * MW'(br_i);
      m_ii <= MW'(ai_i) * MW'(bi_i);
      m_ri <= MW'(ar_i) * MW'(bi_i);
      m_ir <= MW'(ai_i) * MW'(br_i);
    end
  end

  // one extra bit absorbs the add/sub carry, so no precision is lost
  assign s_re = PW'(m_rr) - PW'(m_ii);
  assign s_im = PW'(m_ri) + PW'(m_ir);

  if (STAGES == 1) begin : g_nodly
    assign pr_o = s_re;
    assign pi_o = s_im;
  end else begin : g_dly
    logic signed [PW-1:0] dly_re [STAGES-1];
    logic signed [PW-1:0] dly_im [STAGES-1];

    // remaining stages: plain delay of the summed product
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        for (int i = 0; i < STAGES - 1; i++) begin
          dly_re[i] <= '0;
          dly_im[i] <= '0;
        end
      end else if (ce_i) begin
        dly_re[0] <= s_re;
        dly_im[0] <= s_im;
        for (int i = 1; i < STAGES - 1; i++) begin
          dly_re[i] <= dly_re[i-1];
          dly_im[i] <= dly_im[i-1];
        end
      end
    end

    assign pr_o = dly_re[STAGES-2];
    assign pi_o = dly_im[STAGES-2];
  end

endmodule

// File: rtl/fft_radix2_bfly_pipe.sv
// Streaming radix-2 butterfly, DIF or DIT selected per beat, optional /2
// scaling per beat, round-half-up twiddle rounding and saturating outputs
// with sticky overflow flags. One global enable stalls the whole pipe.
module fft_radix2_bfly_pipe
  import fft_pkg::*;
#(
  parameter int  WIDTH      = 16,
  parameter int  WN_WIDTH   = 14,
  parameter int  MUL_STAGES = 3,
  localparam int TW         = tw_width(WN_WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             dif_i,
  input  logic             scale_i,
  input  logic [WIDTH-1:0] x1_real_i,
  input  logic [WIDTH-1:0] x1_imag_i,
  input  logic [WIDTH-1:0] x2_real_i,
  input  logic [WIDTH-1:0] x2_imag_i,
  input  logic [TW-1:0]    w_real_i,
  input  logic [TW-1:0]    w_imag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] X1_real_o,
  output logic [WIDTH-1:0] X1_imag_o,
  output logic [WIDTH-1:0] X2_real_o,
  output logic [WIDTH-1:0] X2_imag_o,
  output logic [3:0]       ovf_o,
  input  logic             ovf_clr_i
);

  localparam int DW     = WIDTH + 1;       // stage-0 operand width
  localparam int PW     = DW + TW + 1;     // full-precision product width
  localparam int STAGES = MUL_STAGES + 1;  // vld_pipe[STAGES] is the output reg

  logic                 ce;
  logic [STAGES:0]      vld_pipe;

  logic signed [DW-1:0] x1r, x1i, x2r, x2i;

  // A path (sum or x1) plus mode: index 0 is stage 0, MUL_STAGES lines up
  // with the multiplier output
  logic signed [DW-1:0] a_re_q [MUL_STAGES+1];
  logic signed [DW-1:0] a_im_q [MUL_STAGES+1];
  bfly_mode_t           mode_q [MUL_STAGES+1];

  // B path and twiddle only live in stage 0, then enter the multiplier
  logic signed [DW-1:0] b_re_q, b_im_q;
  logic signed [TW-1:0] w_re_q, w_im_q;

  logic signed [PW-1:0] p_re, p_im;

  acc_t                 pre  [4];
  acc_t                 post [4];
  logic [3:0]           hit;
  logic [WIDTH-1:0]     sat_v [4];
  logic [3:0]           ovf_set;

  assign ce      = !valid_o | ready_i;
  assign ready_o = ce;
  assign valid_o = vld_pipe[STAGES];

  assign x1r = DW'($signed(x1_real_i));
  assign x1i = DW'($signed(x1_imag_i));
  assign x2r = DW'($signed(x2_real_i));
  assign x2i = DW'($signed(x2_imag_i));

  // stage 0 operand prep plus the A-path / mode alignment delay
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_pipe <= '0;
      b_re_q   <= '0;
      b_im_q   <= '0;
      w_re_q   <= '0;
      w_im_q   <= '0;
      for (int i = 0; i <= MUL_STAGES; i++) begin
        a_re_q[i] <= '0;
        a_im_q[i] <= '0;
        mode_q[i] <= '0;
      end
    end else if (ce) begin
      vld_pipe  <= {vld_pipe[STAGES-1:0], valid_i};
      a_re_q[0] <= dif_i ? x1r + x2r : x1r;
      a_im_q[0] <= dif_i ? x1i + x2i : x1i;
      b_re_q    <= dif_i ? x1r - x2r : x2r;
      b_im_q    <= dif_i ? x1i - x2i : x2i;
      w_re_q    <= $signed(w_real_i);
      w_im_q    <= $signed(w_imag_i);
      mode_q[0] <= '{dif: dif_i, scale: scale_i};
      for (int i = 1; i <= MUL_STAGES; i++) begin
        a_re_q[i] <= a_re_q[i-1];
        a_im_q[i] <= a_im_q[i-1];
        mode_q[i] <= mode_q[i-1];
      end
    end
  end

  cmul_pipe #(
    .AW     (DW),
    .BW     (TW),
    .STAGES (MUL_STAGES)
  ) u_cmul (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .ce_i    (ce),
    .ar_i    (b_re_q),
    .ai_i    (b_im_q),
    .br_i    (w_re_q),
    .bi_i    (w_im_q),
    .pr_o    (p_re),
    .pi_o    (p_im)
  );

  // final stage: combine, optional halving, saturation
  always_comb begin
    acc_t a_re, a_im, r_re, r_im;
    a_re = acc_t'(a_re_q[MUL_STAGES]);
    a_im = acc_t'(a_im_q[MUL_STAGES]);
    r_re = round_half_up(acc_t'(p_re), WN_WIDTH);
    r_im = round_half_up(acc_t'(p_im), WN_WIDTH);
    if (mode_q[MUL_STAGES].dif) begin
      pre[OVF_X1_RE] = a_re;
      pre[OVF_X1_IM] = a_im;
      pre[OVF_X2_RE] = r_re;
      pre[OVF_X2_IM] = r_im;
    end else begin
      pre[OVF_X1_RE] = a_re + r_re;
      pre[OVF_X1_IM] = a_im + r_im;
      pre[OVF_X2_RE] = a_re - r_re;
      pre[OVF_X2_IM] = a_im - r_im;
    end
    for (int k = 0; k < 4; k++) begin
      // (v+1)>>>1 is round-half-up with one fractional bit
      post[k]  = mode_q[MUL_STAGES].scale ? round_half_up(pre[k], 1) : pre[k];
      hit[k]   = sat_hit(post[k], WIDTH);
      sat_v[k] = WIDTH'(saturate(post[k], WIDTH));
    end
  end

  // only a real beat landing in the output register may raise a flag
  assign ovf_set = (ce && vld_pipe[STAGES-1]) ? hit : 4'b0000;

  // output register and sticky flags; a set in the clear cycle wins
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      X1_real_o <= '0;
      X1_imag_o <= '0;
      X2_real_o <= '0;
      X2_imag_o <= '0;
      ovf_o     <= '0;
    end else begin
      if (ce) begin
        X1_real_o <= sat_v[OVF_X1_RE];
        X1_imag_o <= sat_v[OVF_X1_IM];
        X2_real_o <= sat_v[OVF_X2_RE];
        X2_imag_o <= sat_v[OVF_X2_IM];
      end
      ovf_o <= (ovf_clr_i ? 4'b0000 : ovf_o) | ovf_set;
    end
  end

endmodule

// File: tb/tb_fft_radix2_bfly_pipe.sv
// Bench for the radix-2 butterfly: directed cases, saturation/flag handling,
// backpressure, random streaming and reset mid-stream, all scored against an
// integer reference model and an in-order queue of expected results.
module tb_fft_radix2_bfly_pipe;

  localparam int WIDTH = 16;
  localparam int WN    = 14;
  localparam int MULS  = 3;
  localparam int LAT   = MULS + 2;
  localparam int TW    = WN + 2;

  logic             clk_i = 0;
  logic             rst_n_i;
  logic             valid_i, ready_o, dif_i, scale_i;
  logic [WIDTH-1:0] x1_real_i, x1_imag_i, x2_real_i, x2_imag_i;
  logic [TW-1:0]    w_real_i, w_imag_i;
  logic             valid_o, ready_i;
  logic [WIDTH-1:0] X1_real_o, X1_imag_o, X2_real_o, X2_imag_o;
  logic [3:0]       ovf_o;
  logic             ovf_clr_i;

  fft_radix2_bfly_pipe #(.WIDTH(WIDTH), .WN_WIDTH(WN), .MUL_STAGES(MULS)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .valid_i(valid_i), .ready_o(ready_o),
    .dif_i(dif_i), .scale_i(scale_i),
    .x1_real_i(x1_real_i), .x1_imag_i(x1_imag_i),
    .x2_real_i(x2_real_i), .x2_imag_i(x2_imag_i),
    .w_real_i(w_real_i), .w_imag_i(w_imag_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .X1_real_o(X1_real_o), .X1_imag_o(X1_imag_o),
    .X2_real_o(X2_real_o), .X2_imag_o(X2_imag_o),
    .ovf_o(ovf_o), .ovf_clr_i(ovf_clr_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    longint     x1r, x1i, x2r, x2i;
    logic [3:0] hits;
  } exp_t;

  exp_t       exp_q [$];
  logic [3:0] ovf_m;
  bit         front_shown, running, clr_prev, rnd_ready, rnd_clr;
  int         n_vec, n_err, n_out;

  task automatic chk(input string tag, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint floor_div(input longint n, input longint d);
    longint q;
    q = n / d;
    if ((n % d != 0) && ((n < 0) != (d < 0))) q = q - 1;
    return q;
  endfunction

  function automatic longint clip(input longint v, output bit hit);
    longint mx, mn;
    mx = (64'sd1 <<< (WIDTH - 1)) - 1;
    mn = -(64'sd1 <<< (WIDTH - 1));
    hit = (v > mx) || (v < mn);
    return (v > mx) ? mx : (v < mn) ? mn : v;
  endfunction

  // butterfly straight from the arithmetic definition
  function automatic exp_t model(input bit dif, input bit scale,
                                 input longint x1r, input longint x1i,
                                 input longint x2r, input longint x2i,
                                 input longint wr, input longint wi);
    exp_t   e;
    longint ar, ai, br, bi, pr, pi, rr, ri;
    longint v [4];
    bit     h;
    if (dif) begin
      ar = x1r + x2r; ai = x1i + x2i; br = x1r - x2r; bi = x1i - x2i;
    end else begin
      ar = x1r; ai = x1i; br = x2r; bi = x2i;
    end
    pr = br * wr - bi * wi;
    pi = br * wi + bi * wr;
    rr = floor_div(pr + (64'sd1 <<< (WN - 1)), 64'sd1 <<< WN);
    ri = floor_div(pi + (64'sd1 <<< (WN - 1)), 64'sd1 <<< WN);
    if (dif) begin
      v[0] = ar; v[1] = ai; v[2] = rr; v[3] = ri;
    end else begin
      v[0] = ar + rr; v[1] = ai + ri; v[2] = ar - rr; v[3] = ai - ri;
    end
    e.hits = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      if (scale) v[k] = floor_div(v[k] + 1, 2);
      v[k] = clip(v[k], h);
      e.hits[k] = h;
    end
    e.x1r = v[0]; e.x1i = v[1]; e.x2r = v[2]; e.x2i = v[3];
    return e;
  endfunction

  always @(posedge clk_i) clr_prev = ovf_clr_i;

  // random sink readiness and random flag clears
  always @(posedge clk_i) begin
    #1;
    if (rnd_ready) ready_i = ($urandom_range(0, 3) != 0);
    if (rnd_clr)   ovf_clr_i = ($urandom_range(0, 15) == 0);
  end

  // scoreboard: compare the head result, track sticky flags, record accepts
  always @(negedge clk_i) begin
    if (rst_n_i && running) begin
      if (clr_prev) ovf_m = 4'b0000;
      if (valid_o) begin
        if (exp_q.size() == 0) chk("spurious_valid", valid_o, 0);
        else begin
          if (!front_shown) begin
            front_shown = 1;
            ovf_m = ovf_m | exp_q[0].hits;
          end
          chk("X1_re", $signed(X1_real_o), exp_q[0].x1r);
          chk("X1_im", $signed(X1_imag_o), exp_q[0].x1i);
          chk("X2_re", $signed(X2_real_o), exp_q[0].x2r);
          chk("X2_im", $signed(X2_imag_o), exp_q[0].x2i);
          if (ready_i) begin
            void'(exp_q.pop_front());
            front_shown = 0;
            n_out++;
          end
        end
        if (!ready_i) chk("ready_o_stall", ready_o, 0);
      end
      chk("ovf", ovf_o, ovf_m);
      if (valid_i && ready_o)
        exp_q.push_back(model(dif_i, scale_i,
          $signed(x1_real_i), $signed(x1_imag_i),
          $signed(x2_real_i), $signed(x2_imag_i),
          $signed(w_real_i), $signed(w_imag_i)));
    end
  end

  // present one beat and hold it until accepted; returns 1ns after the accept edge
  task automatic send(input bit dif, input bit scale, input int x1r, input int x1i,
                      input int x2r, input int x2i, input int wr, input int wi);
    bit acc;
    valid_i = 1; dif_i = dif; scale_i = scale;
    x1_real_i = 16'(x1r); x1_imag_i = 16'(x1i);
    x2_real_i = 16'(x2r); x2_imag_i = 16'(x2i);
    w_real_i = 16'(wr); w_imag_i = 16'(wi);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk_i) acc = ready_o;
      @(posedge clk_i); #1;
      if (acc) return;
    end
    chk("send_timeout", 0, 1);
  endtask

  task automatic send_rand();
    int v [6];
    for (int k = 0; k < 4; k++)
      v[k] = ($urandom_range(0, 1) == 1) ? int'($signed(16'($urandom)))
                                          : int'($urandom_range(0, 4000)) - 2000;
    for (int k = 4; k < 6; k++) v[k] = int'($signed(16'($urandom)));
    send(1'($urandom), 1'($urandom), v[0], v[1], v[2], v[3], v[4], v[5]);
  endtask

  task automatic idle(input int n);
    valid_i = 0;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    valid_i = 0;
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clk_i);
    #1;
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    int n0, lat;
    n_vec = 0; n_err = 0; n_out = 0; ovf_m = 0;
    running = 0; rnd_ready = 0; rnd_clr = 0; front_shown = 0;
    rst_n_i = 0; valid_i = 0; ready_i = 1; ovf_clr_i = 0; dif_i = 0; scale_i = 0;
    x1_real_i = 0; x1_imag_i = 0; x2_real_i = 0; x2_imag_i = 0;
    w_real_i = 0; w_imag_i = 0;
    #23;
    chk("rst_valid_o", valid_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_X1_re", X1_real_o, 0);
    chk("rst_X2_im", X2_imag_o, 0);
    chk("rst_ready_o", ready_o, 1);
    @(negedge clk_i) rst_n_i = 1;
    @(posedge clk_i); #1;
    running = 1;

    // directed butterflies, back-to-back with alternating modes
    send(1, 0, 100, 50, 20, -10, 16384, 0);
    send(1, 0, 100, 50, 20, -10, 0, -16384);
    send(0, 0, 1000, 0, 200, 100, 0, -16384);
    send(1, 0, 100, 50, 20, -10, 16384, 0);
    send(0, 0, 1000, 0, 200, 100, 0, -16384);
    send(1, 1, 101, -51, 3, 7, 11585, -11585);
    drain();

    // saturation, scaled variant, clear pulse
    send(1, 0, 32767, -32768, 32767, -32768, 16384, 0);
    drain();
    send(1, 1, 32767, -32768, 32767, -32768, 16384, 0);
    drain();
    ovf_clr_i = 1; @(posedge clk_i); #1; ovf_clr_i = 0;
    idle(2);

    // clear lands in the same cycle as a new overflow: the set must win
    send(1, 0, 32767, -32768, 32767, -32768, 16384, 0);
    valid_i = 0;
    repeat (LAT - 2) @(posedge clk_i);
    #1 ovf_clr_i = 1;
    @(posedge clk_i); #1 ovf_clr_i = 0;
    drain();
    ovf_clr_i = 1; @(posedge clk_i); #1; ovf_clr_i = 0;

    // backpressure: 8 beats, sink stalls 3 cycles mid-stream
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand();
        valid_i = 0;
      end
      begin
        repeat (6) @(posedge clk_i);
        #1 ready_i = 0;
        repeat (3) @(posedge clk_i);
        #1 ready_i = 1;
      end
    join
    drain();
    chk("bp_count", n_out - n0, 8);

    // random streaming with random stalls and flag clears
    rnd_ready = 1; rnd_clr = 1;
    for (int i = 0; i < 400; i++) begin
      send_rand();
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    valid_i = 0;
    rnd_ready = 0; rnd_clr = 0;
    @(posedge clk_i); #2;
    ready_i = 1; ovf_clr_i = 0;
    drain();

    // reset with beats in flight
    send(1, 0, 32767, 0, 32767, 0, 16384, 0);
    drain();
    send_rand(); send_rand(); send_rand();
    #2;
    running = 0;
    rst_n_i = 0;
    #1;
    chk("midrst_valid_o", valid_o, 0);
    chk("midrst_ovf", ovf_o, 0);
    exp_q.delete(); ovf_m = 0; front_shown = 0; valid_i = 0;
    @(negedge clk_i) rst_n_i = 1;
    @(posedge clk_i); #1;
    running = 1;

    // first beat after reset: count enabled cycles including the accept cycle
    send(0, 0, 5, 6, 7, 8, 16384, 0);
    valid_i = 0;
    lat = 1;
    while (lat < 20 && !valid_o) begin
      @(posedge clk_i); #1;
      lat++;
    end
    chk("latency", lat, LAT);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
